serial_rx_deserializer: RTL and testbench
=========================================

SERIAL_RX_DESERIALIZER -- requirements
Module: serial_rx_deserializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload bits per frame.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port data, output, DATA_BITS bits: last correctly framed payload.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when data has been updated.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is bad.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; rx_s is the second stage, and all logic uses rx_s only.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 IDLE SHALL enter START on a falling edge of rx_s (previous rx_s = 1, current = 0); cycle T0 is the first cycle rx_s = 0.
REQ-013 START SHALL sample rx_s at T0 + CLKS_PER_BIT/2.
- rx_s = 0: enter DATA.
- rx_s = 1: false start; return to IDLE, no pulses.
REQ-014 DATA SHALL sample bit i (i = 0..DATA_BITS-1) at T0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
- Shift in LSB first.
- Enter STOP after bit DATA_BITS-1.
REQ-015 STOP SHALL sample rx_s at T0 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT.
REQ-016 Stop sample = 1: on the following cycle, data SHALL take the shifted payload and valid SHALL be 1 for exactly one cycle.
REQ-017 Stop sample = 0: on the following cycle, frame_err SHALL be 1 for exactly one cycle and data SHALL keep its previous value.
REQ-018 After the stop sample, the FSM SHALL return to IDLE; a new start requires a fresh 1->0 edge, so a line held low never retriggers.
REQ-019 valid and frame_err SHALL never be high in the same cycle.
REQ-020 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL reset to 0 on every state entry.
- It SHALL not wrap mid-bit.
REQ-021 rx transitions during DATA or STOP other than at sample points SHALL have no effect.
REQ-022 A start edge arriving during the valid or frame_err pulse cycle SHALL be detected normally.

Reset
REQ-023 rst low SHALL immediately force:
- state IDLE, counters 0, shift register 0;
- data 0, valid 0, frame_err 0, busy 0;
- both synchronizer flops and the edge-history flop to 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse.
- After release, reception resumes only on a new falling edge.
REQ-025 Reset release SHALL be synchronous to clk, so the FSM leaves reset cleanly.

Verification (CLKS_PER_BIT = 4, DATA_BITS = 8)
REQ-026 Send 0xA5 with 4-cycle bits and stop = 1 -> valid pulses once, at T0 + 39, with data = 0xA5; frame_err stays 0.
REQ-027 Send 0x3C with stop = 0 -> frame_err pulses once at T0 + 39; valid stays 0; data keeps its previous value.
REQ-028 Pull rx low for 1 bit-time minus 3 cycles (glitch) -> false start; busy returns to 0; no pulses.
REQ-029 Assert rst at T0 + 20 of a 0xFF frame -> outputs reset immediately, no pulses.
- A following 0x81 frame is then received correctly.
REQ-030 Send back-to-back frames 0x00, 0xFF, 0x55 with no idle gap beyond the stop bit -> three valid pulses carrying those values in order.
REQ-031 Hold rx low for 40 cycles after a framing error -> no further pulses until rx returns high and falls again.

Source files
------------

// File: rtl/serial_rx_deserializer.sv
// rtl/serial_rx_deserializer.sv - oversampling serial frame receiver (start, LSB-first payload, stop)
module serial_rx_deserializer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Counter values at which a sample is taken: mid start bit, then one full bit later each time.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_IDX  = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic                 rst_meta;
   logic                 rst_n_int;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 rx_prev;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta  <= 1'b0;
         rst_n_int <= 1'b0;
      end else begin
         rst_meta  <= 1'b1;
         rst_n_int <= rst_meta;
      end
   end

   // Two-flop synchronizer for rx plus one history flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Frame FSM: counts bit periods from the start edge and samples rx_s at each bit centre.
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (rx_prev && !rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == LAST_IDX) begin
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (rx_s) begin
                     data  <= shreg;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_rx_deserializer.sv
// tb/tb_serial_rx_deserializer.sv - randomized bench with a line-history reference model
module tb_serial_rx_deserializer;

   localparam int CPB  = 4;
   localparam int DB   = 8;
   localparam int HALF = CPB / 2;

   logic          clk;
   logic          rst;
   logic          rx;
   logic [DB-1:0] data;
   logic          valid;
   logic          frame_err;
   logic          busy;

   serial_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit hist [0:131071];
   bit in_reset = 1'b1;

   // model state
   bit            pend = 1'b0;
   int            t0   = 0;
   logic [DB-1:0] mdata = '0;

   // observed pulses
   int            vcyc[$];
   logic [DB-1:0] vdat[$];
   int            fcyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // synchronized line value during cycle k is the line as driven two cycles earlier
   function automatic bit rxs(input int k);
      return (k >= 2) ? hist[k-2] : 1'b1;
   endfunction

   always @(posedge clk) begin
      hist[cyc] = rx;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      int  c;
      bit  ev;
      bit  ef;
      c  = cyc;
      ev = 1'b0;
      ef = 1'b0;
      if (in_reset) begin
         pend  = 1'b0;
         mdata = '0;
      end else if (pend) begin
         if (c == t0 + HALF + 1 && rxs(t0 + HALF)) begin
            pend = 1'b0;
         end else if (c == t0 + HALF + (DB + 1) * CPB + 1) begin
            if (rxs(t0 + HALF + (DB + 1) * CPB)) begin
               for (int i = 0; i < DB; i++) mdata[i] = rxs(t0 + HALF + (i + 1) * CPB);
               ev = 1'b1;
            end else begin
               ef = 1'b1;
            end
            pend = 1'b0;
         end
      end
      chk("valid", {31'd0, valid}, {31'd0, ev});
      chk("frame_err", {31'd0, frame_err}, {31'd0, ef});
      chk("busy", {31'd0, busy}, {31'd0, pend});
      chk("data", {24'd0, data}, {24'd0, mdata});
      if (valid) begin
         vcyc.push_back(c);
         vdat.push_back(data);
      end
      if (frame_err) fcyc.push_back(c);
      if (!in_reset && !pend && c >= 1 && rxs(c - 1) && !rxs(c)) begin
         pend = 1'b1;
         t0   = c;
      end
   end

   // called at #1 after a rising edge; holds v on the line for n cycles
   task automatic drive(input bit v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [DB-1:0] b, input bit stop, input bit noise,
                             output int start);
      start = cyc;
      drive(1'b0, CPB);
      for (int i = 0; i < DB; i++) begin
         if (noise && ($urandom_range(0, 2) == 0)) begin
            drive(~b[i], 1);
            drive(b[i], CPB - 1);
         end else begin
            drive(b[i], CPB);
         end
      end
      drive(stop, CPB);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst      = 1'b0;
      rx       = 1'b1;
      in_reset = 1'b1;
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", {24'd0, data}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (8) @(posedge clk);
      #1 in_reset = 1'b0;
   endtask

   initial begin
      int s;
      int nv;
      int nf;
      int s1;
      int s2;
      int s3;
      logic [DB-1:0] b;
      rst = 1'b1;
      rx  = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      chk("por_data", {24'd0, data}, 32'd0);
      chk("por_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (8) @(posedge clk);
      #1 in_reset = 1'b0;
      drive(1'b1, 10);

      // 0xA5, good stop: single valid at T0+39
      nv = vcyc.size(); nf = fcyc.size();
      send_frame(8'hA5, 1'b1, 1'b0, s);
      drive(1'b1, 10);
      chk("a5_nvalid", vcyc.size() - nv, 32'd1);
      chk("a5_nferr", fcyc.size() - nf, 32'd0);
      if (vcyc.size() > nv) begin
         chk("a5_cycle", vcyc[nv], s + 2 + 39);
         chk("a5_data", {24'd0, vdat[nv]}, 32'h0A5);
      end

      // 0x3C, bad stop: frame_err at T0+39, data retained
      nv = vcyc.size(); nf = fcyc.size();
      send_frame(8'h3C, 1'b0, 1'b0, s);
      drive(1'b1, 10);
      chk("3c_nvalid", vcyc.size() - nv, 32'd0);
      chk("3c_nferr", fcyc.size() - nf, 32'd1);
      if (fcyc.size() > nf) chk("3c_cycle", fcyc[nf], s + 2 + 39);
      chk("3c_data_kept", {24'd0, data}, 32'h0A5);

      // glitch shorter than half a bit: false start
      nv = vcyc.size(); nf = fcyc.size();
      drive(1'b0, CPB - 3);
      drive(1'b1, 12);
      chk("glitch_pulses", (vcyc.size() - nv) + (fcyc.size() - nf), 32'd0);
      chk("glitch_busy", {31'd0, busy}, 32'd0);

      // reset at T0+20 of a 0xFF frame, then 0x81
      nv = vcyc.size(); nf = fcyc.size();
      drive(1'b0, CPB);
      drive(1'b1, 16);
      drive(1'b1, 2);
      chk("midframe_busy", {31'd0, busy}, 32'd1);
      do_reset();
      drive(1'b1, 6);
      chk("reset_abort_pulses", (vcyc.size() - nv) + (fcyc.size() - nf), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0, s);
      drive(1'b1, 6);
      chk("x81_nvalid", vcyc.size() - nv, 32'd1);
      if (vcyc.size() > nv) chk("x81_data", {24'd0, vdat[nv]}, 32'h081);

      // back-to-back 0x00, 0xFF, 0x55
      nv = vcyc.size();
      send_frame(8'h00, 1'b1, 1'b0, s1);
      send_frame(8'hFF, 1'b1, 1'b0, s2);
      send_frame(8'h55, 1'b1, 1'b0, s3);
      drive(1'b1, 8);
      chk("b2b_nvalid", vcyc.size() - nv, 32'd3);
      if (vcyc.size() >= nv + 3) begin
         chk("b2b_d0", {24'd0, vdat[nv]}, 32'h000);
         chk("b2b_d1", {24'd0, vdat[nv+1]}, 32'h0FF);
         chk("b2b_d2", {24'd0, vdat[nv+2]}, 32'h055);
         chk("b2b_c2", vcyc[nv+2], s3 + 2 + 39);
      end

      // framing error then line held low: no retrigger
      nf = fcyc.size();
      send_frame(8'h12, 1'b0, 1'b0, s);
      nv = vcyc.size();
      drive(1'b0, 40);
      chk("held_low_busy", {31'd0, busy}, 32'd0);
      drive(1'b1, 10);
      chk("held_low_nferr", fcyc.size() - nf, 32'd1);
      chk("held_low_nvalid", vcyc.size() - nv, 32'd0);

      // randomized traffic: frames, bad stops, glitches, gaps, mid-bit noise
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            drive(1'b0, $urandom_range(1, HALF));
            drive(1'b1, CPB);
         end else begin
            b = DB'($urandom);
            send_frame(b, ($urandom_range(0, 4) != 0), 1'b1, s);
         end
         drive(1'b1, $urandom_range(0, 5));
      end
      drive(1'b1, 60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
